fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction fetch stage for the RV32I pipeline.
- Owns the PC and issues sequential word fetches to instruction memory.
- Buffers returned instructions for decode.
- Consumes the execute-stage redirect (branch_taken/jump and target), which squashes wrong-path fetches and restarts at the target.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC fetched first after reset
DEPTH, 2, instruction buffer entries and max outstanding fetches (power of two, >=2)

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address
imem_resp_valid  input  1  response valid; in order, one per accepted request, latency >=1 cycle, always accepted
imem_resp_data  input  XLEN  fetched instruction
redirect_valid  input  1  execute stage redirect (taken branch/jump)
redirect_target  input  XLEN  redirect address; bits[1:0] ignored
inst_valid  output  1  buffer head valid to decode
inst_ready  input  1  decode accepts head
inst_data  output  XLEN  head instruction
inst_pc  output  XLEN  PC of head instruction

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n). Assertion clears everything immediately, including mid-operation.
- Reset values:
  - pc=RESET_PC; inflight=0; drop_cnt=0; buffer empty.
  - imem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0.
  - imem_req_addr=RESET_PC.
- Request issue:
  - imem_req_valid = !redirect_valid && (inflight + buf_count < DEPTH).
  - imem_req_addr = pc.
  - First request in the first clock after reset release.
  - Handshake (valid & ready): pc <= pc+4, with 32-bit wrap (0xFFFF_FFFC -> 0x0).
  - The PC of each accepted request is pushed into an in-order pc queue (DEPTH entries).
  - Once asserted, valid and addr hold stable until ready. Sole exception: a redirect may withdraw the request.
- Inflight counter:
  - +1 on request handshake, -1 on imem_resp_valid; both in the same cycle = no change.
  - Never exceeds DEPTH.
- Response handling:
  - If drop_cnt>0, the response is discarded, drop_cnt decrements and its pc-queue entry pops.
  - Otherwise {data, pc-queue head} is written into the buffer. Space is guaranteed by the credit rule, so there is no overflow path.
  - Registered: a response at cycle N gives inst_valid at N+1 (if the buffer was empty).
- Buffer: FIFO of DEPTH entries.
  - inst_valid = count!=0 && !redirect_valid.
  - Pop on inst_valid & inst_ready.
  - Simultaneous push and pop keeps count unchanged; a push into an empty buffer with a pop in the same cycle is not possible (registered output).
- Redirect (redirect_valid=1 at cycle N), all at the N edge:
  - pc <= {redirect_target[31:2],2'b00}.
  - Buffer flushed (count=0).
  - drop_cnt <= inflight - (imem_resp_valid ? 1 : 0).
  - Any response at N is discarded.
  - No request issued at N; first target request at N+1 (redirect-to-request latency 1 cycle).
  - Back-to-back redirects: the last one wins; the drop_cnt formula stays correct because inflight counts stale fetches.
- Redirect takes priority over all same-cycle events (response, pop, request).
- Width rules: all PC arithmetic is modulo 2^32; bits[1:0] of pc are always 0.

Test Plan:
- Sequential fetch:
  - Stimulus: RESET_PC=0x100; memory always ready, 1-cycle latency; inst_ready=1.
  - Required: requests 0x100, 0x104, 0x108 on consecutive cycles; inst_pc sequence identical; first inst_valid 2 cycles after the first handshake.
- Decode backpressure:
  - Stimulus: inst_ready=0.
  - Required: exactly 2 handshakes, then imem_req_valid=0; buffer holds 0x100/0x104. Releasing inst_ready resumes requests at 0x108.
- Squash:
  - Stimulus: 2 requests in flight (latency 3); redirect_valid with target 0x2002.
  - Required: next request addr 0x2000 one cycle later; both old responses dropped; first inst_pc seen = 0x2000.
- Redirect with same-cycle response and pop:
  - Stimulus: inflight=2, imem_resp_valid=1, inst_ready=1, buffer holding 1 entry.
  - Required: inst_valid=0 that cycle; buffer empty after; drop_cnt=1; only target-path instructions delivered.
- Wrap-around:
  - Stimulus: redirect to 0xFFFF_FFF8.
  - Required: request addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Mid-run reset:
  - Stimulus: assert reset_n=0 with 2 inflight and a full buffer.
  - Required: outputs clear immediately without a clock edge; after release, first request addr=RESET_PC and stale responses are not delivered (memory model also reset).

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus bundle: imem request/response, execute redirect and decode handoff.
// Carries no state, so it adds no latency.
// The request and decode channels are valid/ready; the imem response is always accepted.
interface fetch_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_target, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_target, inst_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// RV32I fetch: owns the PC, issues word fetches, and buffers responses for decode.
// Latency: a response is visible on inst_valid one cycle later; a redirect's first fetch follows one cycle later.
// Backpressure: new fetches stall while inflight + buffered reaches DEPTH, so the buffer can never overflow.
module fetch_pc_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    fetch_pc_unit_if.master  bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   count;

    logic [XLEN-1:0] pcq     [DEPTH];
    logic [PW-1:0]   pcq_wr;
    logic [PW-1:0]   pcq_rd;
    logic [XLEN-1:0] buf_dat [DEPTH];
    logic [XLEN-1:0] buf_pc  [DEPTH];
    logic [PW-1:0]   buf_wr;
    logic [PW-1:0]   buf_rd;

    logic credit_ok;
    logic req_vld;
    logic req_fire;
    logic resp_keep;
    logic inst_vld;
    logic pop;

    always_comb begin
        credit_ok = ({1'b0, inflight} + {1'b0, count}) < DEPTH_C;
        // Gating by reset_n keeps the request low while reset is held.
        req_vld   = reset_n && !bus.redirect_valid && credit_ok;
        req_fire  = req_vld && bus.imem_req_ready;
        resp_keep = bus.imem_resp_valid && (drop_cnt == '0) && !bus.redirect_valid;
        inst_vld  = (count != '0) && !bus.redirect_valid;
        pop       = inst_vld && bus.inst_ready;
    end

    assign bus.imem_req_valid = req_vld;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_vld;
    assign bus.inst_data      = (count != '0) ? buf_dat[buf_rd] : '0;
    assign bus.inst_pc        = (count != '0) ? buf_pc[buf_rd]  : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc       <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
            count    <= '0;
            pcq_wr   <= '0;
            pcq_rd   <= '0;
            buf_wr   <= '0;
            buf_rd   <= '0;
        end else begin
            // The pc queue keeps tracking stale fetches across a redirect; only their data is dropped.
            if (req_fire) pcq_wr <= pcq_wr + PW'(1);
            if (bus.imem_resp_valid) pcq_rd <= pcq_rd + PW'(1);

            case ({req_fire, bus.imem_resp_valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase

            if (bus.redirect_valid) begin
                pc       <= bus.redirect_target & ~XLEN'(3);
                drop_cnt <= inflight - CW'(bus.imem_resp_valid);
                count    <= '0;
                buf_wr   <= '0;
                buf_rd   <= '0;
            end else begin
                if (req_fire) pc <= pc + XLEN'(4);
                if (bus.imem_resp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
                if (resp_keep) buf_wr <= buf_wr + PW'(1);
                if (pop)       buf_rd <= buf_rd + PW'(1);
                case ({resp_keep, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (req_fire) pcq[pcq_wr] <= pc;
        if (resp_keep) begin
            buf_dat[buf_wr] <= bus.imem_resp_data;
            buf_pc[buf_wr]  <= pcq[pcq_rd];
        end
    end
endmodule
